rom_sequencer: RTL and testbench
================================

Name: rom_sequencer

Overview:
Parametrised ROM playback engine: generates addresses for an external synchronous ROM (registered address, 1-cycle read latency) and presents the read data with a valid strobe. It replaces a free-running address counter with a start/end window, a programmable rate divider, four playback modes (loop, one-shot, ping-pong, hold), pause and single-step. It sits between board-level control inputs (already debounced and synchronised upstream) and the ROM/LED output path.

Parameters:
ADDR_W, 6, ROM address width (depth = 2**ADDR_W)
DATA_W, 8, ROM data width
DIV_W, 24, width of rate-divider reload value

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
run  input  1  level; 1 = play, 0 = pause / return to idle from DONE
step  input  1  single-cycle pulse; one advance when paused or idle
restart  input  1  single-cycle pulse; abort to IDLE
mode  input  2  0 LOOP, 1 ONESHOT, 2 PINGPONG, 3 HOLD
div  input  DIV_W  advance period minus 1 (0 = advance every cycle)
start_addr  input  ADDR_W  first address of window
end_addr  input  ADDR_W  last address of window
rom_addr  output  ADDR_W  address to ROM
rom_q  input  DATA_W  ROM read data (valid 1 cycle after rom_addr sampled)
dout  output  DATA_W  registered ROM data
dout_valid  output  1  1-cycle pulse, dout holds a newly fetched word
busy  output  1  state is RUN or PAUSE
done  output  1  ONESHOT reached end_addr
cfg_err  output  1  start_addr > end_addr at last load attempt

Behaviour:
- Reset (rst=0, async): state IDLE, rom_addr=0, dout=0, dout_valid=0, busy=0, done=0, cfg_err=0, dir=up, divider count=0, fetch pipeline flags cleared. Mid-operation reset aborts immediately; in-flight fetches produce no dout_valid.
- States: IDLE, RUN, PAUSE, DONE.
- "Load": rom_addr<=start_addr, dir<=up, divider count<=0, counts as an advance. start_addr/end_addr/mode sampled only in that cycle (latched internally); div read live.
- IDLE: run=1 or step=1 -> if start_addr>end_addr: cfg_err<=1, stay IDLE, no advance; else cfg_err<=0, Load, go RUN (run=1) or PAUSE (step only).
- RUN: divider counts 0..div; tick when count==div, count wraps to 0. On tick, advance per mode. run=0 -> PAUSE (count held). step ignored in RUN.
- PAUSE: run=1 -> RUN, resumes count without reload. step=1 -> one advance immediately, divider not involved, stays PAUSE.
- DONE: rom_addr held, done=1, no advances; run=0 -> IDLE (done<=0).
- restart=1 in any state -> IDLE next cycle, done<=0, rom_addr held; has priority over run/step/tick. Pending fetches still complete.
- Advance rules (from address a, latched start S / end E):
  LOOP: a==E -> S, else a+1.
  ONESHOT: a+1; advance landing on E sets done=1 and state DONE (from RUN or PAUSE).
  PINGPONG: dir up: a==E -> a-1 (dir down), else a+1; dir down: a==S -> a+1 (dir up), else a-1. S==E -> address stays, fetch still issued.
  HOLD: address unchanged, fetch still issued (refresh).
  S==E in LOOP/ONESHOT: stays at S; ONESHOT -> DONE at Load.
- No arithmetic wrap beyond window; E=2**ADDR_W-1 legal.
- Fetch pipeline: advance at edge N updates rom_addr; ROM samples at N+1; dout<=rom_q and dout_valid=1 at edge N+2 for exactly one cycle. Fixed latency 2; back-to-back advances (div=0) yield continuous dout_valid.
- busy combinational from state; done, cfg_err registered.

Test Plan:
- LOOP, div=0, S=2, E=4, run=1: rom_addr 2,3,4,2,3 on consecutive cycles; dout = ROM[2],ROM[3],ROM[4]... starting 2 cycles after Load, dout_valid continuous.
- ONESHOT, div=3, S=0, E=2: rom_addr changes every 4 cycles 0->1->2; done=1 and state DONE with addr 2; run=0 -> done=0, busy=0.
- PINGPONG, div=0, S=5, E=7: sequence 5,6,7,6,5,6,7; S=E=9: addr stays 9, dout_valid every cycle.
- Pause/step: LOOP run, drop run at addr 3 -> addr frozen, no dout_valid after 2 cycles; three step pulses -> 4,5,6 each with one dout_valid; run=1 resumes from 6.
- S=10, E=4, run=1 -> cfg_err=1, busy=0, rom_addr unchanged, no dout_valid; fix E=12 -> cfg_err=0, Load at 10.
- Assert rst low mid-RUN at div=0 -> all outputs at reset values same cycle, no dout_valid after release; restart pulse concurrent with tick -> IDLE, no advance.

Source files
------------

// File: rtl/rom_sequencer.sv
// ROM playback engine: drives the address of an external synchronous ROM over a
// start/end window with rate divider, four playback modes, pause and single-step.
module rom_sequencer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;
  typedef enum logic [1:0] {M_LOOP, M_ONESHOT, M_PINGPONG, M_HOLD} mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DIV_W-1:0]  CNT_ONE  = DIV_W'(1);

  state_e              state_q, state_d;
  mode_e               mode_q;
  dir_e                dir_q, dir_d;
  logic [ADDR_W-1:0]   s_q, e_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic                done_d, cfg_err_d;
  logic                load, advance, take_step;
  logic [ADDR_W-1:0]   nxt_addr;
  dir_e                nxt_dir;
  logic                nxt_finish;
  logic                fetch_a, fetch_b;

  // Next address, direction and end-of-playback flag for one advance from rom_addr.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    nxt_addr   = rom_addr;
    nxt_dir    = dir_q;
    nxt_finish = 1'b0;
    case (mode_q)
      M_LOOP: nxt_addr = (rom_addr == e_q) ? s_q : rom_addr + ADDR_ONE;
      M_ONESHOT: begin
        nxt_addr   = (rom_addr == e_q) ? rom_addr : rom_addr + ADDR_ONE;
        nxt_finish = (nxt_addr == e_q);
      end
      M_PINGPONG: begin
        if (s_q == e_q) begin
          nxt_addr = rom_addr;
        end else if (dir_q == DIR_UP) begin
          if (rom_addr == e_q) begin
            nxt_addr = rom_addr - ADDR_ONE;
            nxt_dir  = DIR_DOWN;
          end else begin
            nxt_addr = rom_addr + ADDR_ONE;
          end
        end else begin
          if (rom_addr == s_q) begin
            nxt_addr = rom_addr + ADDR_ONE;
            nxt_dir  = DIR_UP;
          end else begin
            nxt_addr = rom_addr - ADDR_ONE;
          end
        end
      end
      default: nxt_addr = rom_addr;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = rom_addr;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    done_d    = done;
    cfg_err_d = cfg_err;
    load      = 1'b0;
    advance   = 1'b0;
    take_step = 1'b0;

    if (restart) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run || step) begin
            if (start_addr > end_addr) begin
              cfg_err_d = 1'b1;
            end else begin
              cfg_err_d = 1'b0;
              load      = 1'b1;
              advance   = 1'b1;
              addr_d    = start_addr;
              dir_d     = DIR_UP;
              cnt_d     = '0;
              if (mode_e'(mode) == M_ONESHOT && start_addr == end_addr) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = run ? S_RUN : S_PAUSE;
              end
            end
          end
        end
        S_RUN: begin
          if (!run) begin
            state_d = S_PAUSE;
          end else if (cnt_q >= div) begin
            // >= rather than == so a live reduction of div below the count still ticks.
            cnt_d     = '0;
            take_step = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_PAUSE: begin
          if (run) begin
            state_d = S_RUN;
          end else if (step) begin
            take_step = 1'b1;
          end
        end
        default: begin
          if (!run) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
          end
        end
      endcase

      if (take_step) begin
        advance = 1'b1;
        addr_d  = nxt_addr;
        dir_d   = nxt_dir;
        if (nxt_finish) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rom_addr <= '0;
      dir_q    <= DIR_UP;
      cnt_q    <= '0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      s_q      <= '0;
      e_q      <= '0;
      mode_q   <= M_LOOP;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= state_d;
      rom_addr <= addr_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      done     <= done_d;
      cfg_err  <= cfg_err_d;
      if (load) begin
        s_q    <= start_addr;
        e_q    <= end_addr;
        mode_q <= mode_e'(mode);
      end
    end
  end

  // Two-stage fetch tracker: address registered, ROM registers it, then dout captures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_a    <= 1'b0;
      fetch_b    <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      fetch_a    <= advance;
      fetch_b    <= fetch_a;
      dout_valid <= fetch_b;
      if (fetch_b) dout <= rom_q;
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_PAUSE);

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: per-cycle vector tables for address/status outputs and a
// scoreboard of expected ROM words checked whenever dout_valid pulses.
module tb_rom_sequencer;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              run, step, restart;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, busy, done, cfg_err;

  rom_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .restart(restart), .mode(mode),
    .div(div), .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr),
    .rom_q(rom_q), .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] rom_mem [2**ADDR_W];
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  typedef struct {
    logic              run, step, restart;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  div;
    logic [ADDR_W-1:0] s, e;
    logic [ADDR_W-1:0] addr;
    logic              busy, done, cerr, adv;
  } vec_t;

  vec_t              tbl[$];
  logic [DATA_W-1:0] sb[$];
  logic [1:0]        pipe;
  int                checks = 0;
  int                errors = 0;
  logic [1:0]        cur_mode;
  logic [DIV_W-1:0]  cur_div;
  logic [ADDR_W-1:0] cur_s, cur_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit st, input bit rs, input int a,
                     input bit b, input bit d, input bit ce, input bit adv);
    vec_t v;
    v.run = r; v.step = st; v.restart = rs;
    v.mode = cur_mode; v.div = cur_div; v.s = cur_s; v.e = cur_e;
    v.addr = ADDR_W'(a); v.busy = b; v.done = d; v.cerr = ce; v.adv = adv;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    run = v.run; step = v.step; restart = v.restart; mode = v.mode; div = v.div;
    start_addr = v.s; end_addr = v.e;
    if (v.adv) sb.push_back(rom_mem[v.addr]);
    @(posedge clk); #1;
    check({tag, ".addr"},  32'(rom_addr), 32'(v.addr));
    check({tag, ".busy"},  32'(busy),     32'(v.busy));
    check({tag, ".done"},  32'(done),     32'(v.done));
    check({tag, ".cfg"},   32'(cfg_err),  32'(v.cerr));
    check({tag, ".valid"}, 32'(dout_valid), 32'(pipe[1]));
    pipe = {pipe[0], v.adv};
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && dout_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_valid", 32'(dout_valid), 32'd0);
      else check("dout", 32'(dout), 32'(sb.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = DATA_W'(i * 37 + 11);
    rst = 1'b0; run = 0; step = 0; restart = 0; mode = 0; div = '0;
    start_addr = '0; end_addr = '0; pipe = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.addr",  32'(rom_addr), 0);
    check("rst.dout",  32'(dout), 0);
    check("rst.valid", 32'(dout_valid), 0);
    check("rst.busy",  32'(busy), 0);
    check("rst.done",  32'(done), 0);
    check("rst.cfg",   32'(cfg_err), 0);
    rst = 1'b1;

    // LOOP window 2..4 at full rate, then restart coinciding with a tick.
    cur_mode = 2'd0; cur_div = '0; cur_s = 6'd2; cur_e = 6'd4;
    add(1,0,0,2,1,0,0,1); add(1,0,0,3,1,0,0,1); add(1,0,0,4,1,0,0,1);
    add(1,0,0,2,1,0,0,1); add(1,0,0,3,1,0,0,1); add(1,0,0,4,1,0,0,1);
    add(1,0,1,4,0,0,0,0); add(0,0,0,4,0,0,0,0); add(0,0,0,4,0,0,0,0);
    run_tbl("loop");

    // ONESHOT window 0..2 advancing every fourth cycle.
    cur_mode = 2'd1; cur_div = 24'd3; cur_s = 6'd0; cur_e = 6'd2;
    add(1,0,0,0,1,0,0,1);
    for (int k = 0; k < 3; k++) add(1,0,0,0,1,0,0,0);
    add(1,0,0,1,1,0,0,1);
    for (int k = 0; k < 3; k++) add(1,0,0,1,1,0,0,0);
    add(1,0,0,2,0,1,0,1); add(1,0,0,2,0,1,0,0);
    add(0,0,0,2,0,0,0,0); add(0,0,0,2,0,0,0,0);
    run_tbl("oneshot");

    // PINGPONG window 5..7, then a single-address window at 9.
    cur_mode = 2'd2; cur_div = '0; cur_s = 6'd5; cur_e = 6'd7;
    add(1,0,0,5,1,0,0,1); add(1,0,0,6,1,0,0,1); add(1,0,0,7,1,0,0,1);
    add(1,0,0,6,1,0,0,1); add(1,0,0,5,1,0,0,1); add(1,0,0,6,1,0,0,1);
    add(1,0,0,7,1,0,0,1); add(0,0,1,7,0,0,0,0); add(0,0,0,7,0,0,0,0);
    cur_s = 6'd9; cur_e = 6'd9;
    for (int k = 0; k < 4; k++) add(1,0,0,9,1,0,0,1);
    add(0,0,1,9,0,0,0,0); add(0,0,0,9,0,0,0,0);
    run_tbl("pingpong");

    // Pause at 3, three single steps, then resume.
    cur_mode = 2'd0; cur_div = '0; cur_s = 6'd0; cur_e = 6'd7;
    for (int k = 0; k < 4; k++) add(1,0,0,k,1,0,0,1);
    for (int k = 0; k < 3; k++) add(0,0,0,3,1,0,0,0);
    for (int k = 4; k < 7; k++) begin
      add(0,1,0,k,1,0,0,1); add(0,0,0,k,1,0,0,0);
    end
    add(1,0,0,6,1,0,0,0); add(1,0,0,7,1,0,0,1);
    add(0,0,1,7,0,0,0,0); add(0,0,0,7,0,0,0,0);
    run_tbl("pause");

    // Inverted window is refused, then a corrected window loads.
    cur_mode = 2'd0; cur_div = '0; cur_s = 6'd10; cur_e = 6'd4;
    add(1,0,0,7,0,0,1,0); add(1,0,0,7,0,0,1,0);
    cur_e = 6'd12;
    add(1,0,0,10,1,0,0,1); add(1,0,0,11,1,0,0,1);
    add(0,0,1,11,0,0,0,0); add(0,0,0,11,0,0,0,0);
    run_tbl("cfgerr");

    // Asynchronous reset in the middle of a full-rate run.
    cur_mode = 2'd0; cur_div = '0; cur_s = 6'd2; cur_e = 6'd4;
    add(1,0,0,2,1,0,0,1); add(1,0,0,3,1,0,0,1); add(1,0,0,4,1,0,0,1);
    run_tbl("prerst");
    rst = 1'b0;
    #1;
    check("arst.addr",  32'(rom_addr), 0);
    check("arst.dout",  32'(dout), 0);
    check("arst.valid", 32'(dout_valid), 0);
    check("arst.busy",  32'(busy), 0);
    check("arst.done",  32'(done), 0);
    check("arst.cfg",   32'(cfg_err), 0);
    sb.delete();
    pipe = '0;
    repeat (2) @(posedge clk);
    #1;
    check("arst.hold_addr", 32'(rom_addr), 0);
    run = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("arst.quiet[%0d]", k), 32'(dout_valid), 0);
      check($sformatf("arst.idle[%0d]", k), 32'(busy), 0);
    end

    // Step-only load into PAUSE, and a single-address ONESHOT that ends on load.
    add(0,1,0,2,1,0,0,1); add(0,0,0,2,1,0,0,0); add(0,1,0,3,1,0,0,1);
    add(0,0,1,3,0,0,0,0); add(0,0,0,3,0,0,0,0);
    cur_mode = 2'd1; cur_s = 6'd20; cur_e = 6'd20;
    add(1,0,0,20,0,1,0,1); add(0,0,0,20,0,0,0,0);
    add(0,0,0,20,0,0,0,0); add(0,0,0,20,0,0,0,0);
    run_tbl("stepload");

    check("sb_drain", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
